// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module      : pc
// Description : Program-counter register. Din is loaded into Qout on every
//               rising clk edge; there is no enable, so holding the PC means
//               feeding Qout back on Din externally. Resetn is asynchronous
//               and active-low, and forces Qout to RESET_VALUE at once.
//
// Parameters  : WIDTH       - register / data port width (>= 2)
//               RESET_VALUE - value held on Qout while Resetn is low
//
// Ports       : clk        in   clock, rising-edge active
//               Resetn     in   asynchronous active-low reset
//               Din        in   [WIDTH-1:0] next program-counter value
//               Qout       out  [WIDTH-1:0] current program-counter value
//               Misaligned out  registered flag, Din[1:0] != 0 at last load
//                               (only when PC_ALIGN_CHECK_EN is defined)
//
// Build option: define PC_ALIGN_CHECK_EN to add the word-alignment flag.
//
// Revision    : 1.0 - initial release
// ============================================================================

module pc #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] Din,
`ifdef PC_ALIGN_CHECK_EN
  output logic             Misaligned,
`endif
  output logic [WIDTH-1:0] Qout
);

  // Qout is the flop output itself, so there is no path from Din to Qout
  // other than through the clock edge.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      Qout <= RESET_VALUE;
    end else begin
      Qout <= Din;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Flags the value being loaded rather than the old Qout, so the flag
  // always describes the PC currently on Qout. Qout itself is not altered.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      Misaligned <= 1'b0;
    end else begin
      Misaligned <= |Din[1:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc
// Description : Self-checking bench for pc. Each driven cycle pushes the
//               expected Qout (and Misaligned, when PC_ALIGN_CHECK_EN is
//               defined) onto a scoreboard queue; the entry is popped and
//               compared on the falling edge after the loading rising edge.
//               Asynchronous-reset and between-edge hold behaviour is
//               checked directly at mid-cycle points.
//
// Revision    : 1.0 - initial release
// ============================================================================

module tb_pc;

  localparam int               W     = 32;
  localparam logic [W-1:0]     C_RST = '0;

  logic         clk;
  logic         Resetn;
  logic [W-1:0] Din;
  logic [W-1:0] Qout;
`ifdef PC_ALIGN_CHECK_EN
  logic         Misaligned;
`endif

  int n_checks;
  int n_pass;

  logic [W-1:0] exp_q[$];
  logic         exp_m[$];

  pc #(
    .WIDTH      (W),
    .RESET_VALUE(C_RST)
  ) dut (
    .clk       (clk),
    .Resetn    (Resetn),
    .Din       (Din),
`ifdef PC_ALIGN_CHECK_EN
    .Misaligned(Misaligned),
`endif
    .Qout      (Qout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench must never run away.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Pop one scoreboard entry and compare it against the DUT outputs.
  task automatic compare_out(input string tag);
    logic [W-1:0] eq;
    logic         em;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      eq = exp_q.pop_front();
      em = exp_m.pop_front();
      check(tag, Qout, eq);
`ifdef PC_ALIGN_CHECK_EN
      check({tag, "_mis"}, {{(W-1){1'b0}}, Misaligned}, {{(W-1){1'b0}}, em});
`else
      em = em;
`endif
    end
  endtask

  // Drive Din from the falling edge, record the expected result of the next
  // rising edge, then compare on the following falling edge. With
  // release_at_edge set, Resetn is released 1 time unit after the edge, i.e.
  // inside that edge's hold window, so the edge itself still sees reset.
  task automatic step(input string tag, input logic [W-1:0] d,
                      input logic release_at_edge);
    Din = d;
    if (Resetn) begin
      exp_q.push_back(d);
      exp_m.push_back(d[1:0] != 2'b00);
    end else begin
      exp_q.push_back(C_RST);
      exp_m.push_back(1'b0);
    end
    @(posedge clk);
    if (release_at_edge) begin
      #1 Resetn = 1'b1;
    end
    @(negedge clk);
    compare_out(tag);
  endtask

  initial begin
    logic [W-1:0] r;
    n_checks = 0;
    n_pass   = 0;
    Resetn   = 1'b0;
    Din      = '0;

    // Reset is visible before any clock edge.
    #2;
    check("reset_init", Qout, C_RST);
`ifdef PC_ALIGN_CHECK_EN
    check("reset_init_mis", {{(W-1){1'b0}}, Misaligned}, '0);
`endif

    // Release mid-cycle; the first edge with Resetn high loads Din.
    @(negedge clk);
    Resetn = 1'b1;
    Din    = 32'h0000_1111;
    #2;
    check("load_before_edge", Qout, C_RST);
    step("load_1111", 32'h0000_1111, 1'b0);

    // Asynchronous reset mid-cycle clears a loaded value immediately.
    step("load_12345678", 32'h1234_5678, 1'b0);
    #1 Resetn = 1'b0;
    #1;
    check("async_reset_midcycle", Qout, 32'h0000_0000);

    // Din presented only under reset never reaches Qout.
    @(negedge clk);
    step("held_reset_e1", 32'h0000_1111, 1'b0);
    step("held_reset_e2", 32'h0000_1111, 1'b0);
    Resetn = 1'b1;
    step("after_release_0", 32'h0000_0000, 1'b0);

    // Reset released at a rising edge: that edge does not load.
    Resetn = 1'b0;
    #1;
    check("reset_again", Qout, C_RST);
    step("release_edge", 32'h1234_5678, 1'b1);
    step("first_load_after", 32'h1234_5678, 1'b0);

    // Qout holds between edges even when Din changes.
    step("load_aaaa", 32'hAAAA_AAAA, 1'b0);
    #1 Din = 32'h5555_5555;
    #2;
    check("hold_between_edges", Qout, 32'hAAAA_AAAA);
    step("load_5555", 32'h5555_5555, 1'b0);
    step("all_ones", 32'hFFFF_FFFF, 1'b0);

    // Alignment patterns (Misaligned compared only when present).
    step("align_6", 32'h0000_0006, 1'b0);
    step("align_8", 32'h0000_0008, 1'b0);
    step("align_3", 32'h0000_0003, 1'b0);
    step("align_1", 32'h8000_0001, 1'b0);

    // A short burst of random values.
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      step("random", r, 1'b0);
    end

    // Scoreboard must be fully drained.
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
